seg_display_arbiter: RTL and testbench

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

---
 rtl/seg_display_arbiter_pkg.sv | 21 ++
 rtl/seg_display_arbiter_rr_picker.sv | 27 ++
 rtl/seg_display_arbiter.sv | 122 ++++++++++++
 tb/tb_seg_display_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Digit codes are {dp, hex[3:0]}; a slice is four digits packed {d3,d2,d1,d0}.
package seg_pkg;

   localparam int DIGIT_W    = 5;
   localparam int NUM_DIGITS = 4;
   localparam int NUM_REQ    = 4;
   localparam int SLICE_W    = DIGIT_W * NUM_DIGITS;

   localparam logic [SLICE_W-1:0] BLANK_DIGITS = '0;

   typedef enum logic {
      IDLE,
      OWNED
   } state_e;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_picker.sv
// Round-robin picker: first set req bit at or after start, wrapping modulo 4.
module rr_picker
   import seg_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         start,
   output logic               found,
   output logic [1:0]         idx
);

   logic [1:0] cand;

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      found = 1'b0;
      idx   = start;
      cand  = start;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = start + 2'(k);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// Arbitrates four requesters for one four-digit display with a minimum dwell
// (in prescaler ticks) before an owner can be preempted by a competitor.
module seg_display_arbiter
   import seg_pkg::*;
#(
   parameter int                 HOLD_TICKS  = 4,
   parameter int                 PRESCALE_W  = 16,
   parameter logic [SLICE_W-1:0] IDLE_DIGITS = BLANK_DIGITS
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*SLICE_W-1:0] req_digits,
   output logic [NUM_REQ-1:0]         grant,
   output logic [1:0]                 owner,
   output logic                       busy,
   output logic [DIGIT_W-1:0]         digits0,
   output logic [DIGIT_W-1:0]         digits1,
   output logic [DIGIT_W-1:0]         digits2,
   output logic [DIGIT_W-1:0]         digits3,
   output logic                       tick
);

   localparam int DWELL_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
   localparam logic [DWELL_W-1:0] HOLD_MAX = DWELL_W'(HOLD_TICKS);

   state_e              state_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [1:0]          owner_q;
   logic [1:0]          rr_ptr_q;
   logic [DWELL_W-1:0]  dwell_q;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [SLICE_W-1:0]  digits_q, digits_d;

   logic [NUM_REQ-1:0]  pick_req;
   logic [1:0]          pick_start;
   logic                pick_found;
   logic [1:0]          pick_idx;
   logic [SLICE_W-1:0]  slices [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign slices[i] = req_digits[SLICE_W*i +: SLICE_W];
   end

   assign presc_d = presc_q + PRESCALE_W'(1);
   assign tick    = &presc_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) presc_q <= '0;
      else       presc_q <= presc_d;
   end

   // While owned, the picker only sees competitors, starting just past the owner.
   always_comb begin
      pick_req   = req;
      pick_start = rr_ptr_q;
      if (state_q == OWNED) begin
         pick_req   = req & ~grant_q;
         pick_start = owner_q + 2'd1;
      end
   end

   rr_picker u_picker (
      .req   (pick_req),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         dwell_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  state_q <= OWNED;
                  grant_q <= onehot(pick_idx);
                  owner_q <= pick_idx;
                  dwell_q <= '0;
               end
            end
            OWNED: begin
               if (!req[owner_q]) begin
                  state_q  <= IDLE;
                  grant_q  <= '0;
                  rr_ptr_q <= owner_q + 2'd1;
                  dwell_q  <= '0;
               end else if (dwell_q == HOLD_MAX && pick_found) begin
                  grant_q  <= onehot(pick_idx);
                  owner_q  <= pick_idx;
                  rr_ptr_q <= owner_q + 2'd1;
                  dwell_q  <= '0;
               end else if (tick && dwell_q != HOLD_MAX) begin
                  dwell_q <= dwell_q + DWELL_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign digits_d = (|grant_q) ? slices[owner_q] : IDLE_DIGITS;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) digits_q <= IDLE_DIGITS;
      else       digits_q <= digits_d;
   end

   assign grant   = grant_q;
   assign owner   = owner_q;
   assign busy    = |grant_q;
   assign digits0 = digits_q[DIGIT_W*0 +: DIGIT_W];
   assign digits1 = digits_q[DIGIT_W*1 +: DIGIT_W];
   assign digits2 = digits_q[DIGIT_W*2 +: DIGIT_W];
   assign digits3 = digits_q[DIGIT_W*3 +: DIGIT_W];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter with PRESCALE_W=2, HOLD_TICKS=2.
module tb_seg_display_arbiter;

   localparam logic [19:0] IDLE_D = 20'hABCDE;
   localparam logic [19:0] SL0    = 20'h0F0E1;
   localparam logic [19:0] SL1    = 20'h3C2D4;
   localparam logic [19:0] SL2    = 20'h5A5A5;
   localparam logic [19:0] SL3    = 20'hC3C3C;
   localparam logic [19:0] SL0B   = 20'h9E8F7;

   typedef struct {
      logic [3:0] g;
      logic [1:0] o;
      logic       b;
      int         due;
   } gexp_t;

   typedef struct {
      logic [19:0] d;
      int          due;
   } dexp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [79:0] req_digits;
   logic [3:0]  grant;
   logic [1:0]  owner;
   logic        busy;
   logic [4:0]  digits0, digits1, digits2, digits3;
   logic        tick;

   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   int    r_cyc = 0;
   bit    tick_ok = 1'b0;
   gexp_t gq[$];
   dexp_t dq[$];
   logic [3:0]  prev_grant = 4'b0000;
   logic [19:0] prev_dig = IDLE_D;

   seg_display_arbiter #(
      .HOLD_TICKS  (2),
      .PRESCALE_W  (2),
      .IDLE_DIGITS (IDLE_D)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_digits (req_digits),
      .grant      (grant),
      .owner      (owner),
      .busy       (busy),
      .digits0    (digits0),
      .digits1    (digits1),
      .digits2    (digits2),
      .digits3    (digits3),
      .tick       (tick)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_g(input logic [3:0] g, input logic [1:0] o, input logic b, input int due);
      gexp_t e;
      e.g = g; e.o = o; e.b = b; e.due = due;
      gq.push_back(e);
   endtask

   task automatic push_d(input logic [19:0] d, input int due);
      dexp_t e;
      e.d = d; e.due = due;
      dq.push_back(e);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Monitor: pops an expectation whenever grant or the digit word changes.
   always @(negedge clk) begin
      logic [19:0] dw;
      gexp_t ge;
      dexp_t de;
      dw = {digits3, digits2, digits1, digits0};
      if (grant !== prev_grant) begin
         if (gq.size() == 0) begin
            chk("grant_unexpected", {28'b0, grant}, {28'b0, prev_grant});
         end else begin
            ge = gq.pop_front();
            chk("grant", {28'b0, grant}, {28'b0, ge.g});
            chk("owner", {30'b0, owner}, {30'b0, ge.o});
            chk("busy", {31'b0, busy}, {31'b0, ge.b});
            if (ge.due >= 0) chk("grant_cycle", cyc, ge.due);
         end
         prev_grant = grant;
      end
      if (dw !== prev_dig) begin
         if (dq.size() == 0) begin
            chk("digits_unexpected", {12'b0, dw}, {12'b0, prev_dig});
         end else begin
            de = dq.pop_front();
            chk("digits", {12'b0, dw}, {12'b0, de.d});
            if (de.due >= 0) chk("digits_cycle", cyc, de.due);
         end
         prev_dig = dw;
      end
      chk("busy_is_or_grant", {31'b0, busy}, {31'b0, |grant});
      chk("grant_onehot0", {31'b0, $onehot0(grant)}, 32'd1);
      if (tick_ok && cyc > r_cyc)
         chk("tick_phase", {31'b0, tick}, {31'b0, ((cyc - r_cyc) % 4) == 3});
   end

   initial begin
      int g, t1, p, q, c;
      reset = 1'b1;
      req = 4'b0000;
      req_digits = {SL3, SL2, SL1, SL0};
      repeat (2) @(negedge clk);
      chk("rst_grant", {28'b0, grant}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_owner", {30'b0, owner}, 32'd0);
      chk("rst_tick", {31'b0, tick}, 32'd0);
      chk("rst_digits", {12'b0, digits3, digits2, digits1, digits0}, {12'b0, IDLE_D});
      reset = 1'b0;
      r_cyc = cyc;
      tick_ok = 1'b1;
      repeat (12) @(negedge clk);

      // Requesters 1 and 2; 1 wins first, 2 preempts after two counted ticks.
      req = 4'b0110;
      g = cyc + 1;
      push_g(4'b0010, 2'd1, 1'b1, g);
      push_d(SL1, g + 1);
      t1 = g + ((3 - ((g - r_cyc) % 4)) + 4) % 4;
      p = t1 + 4 + 2;
      push_g(4'b0100, 2'd2, 1'b1, p);
      push_d(SL2, p + 1);
      wait_cyc(p);

      // Owner 2 releases; pointer 3 wraps around to requester 0.
      req = 4'b0001;
      push_g(4'b0000, 2'd2, 1'b0, p + 1);
      push_g(4'b0001, 2'd0, 1'b1, p + 2);
      push_d(IDLE_D, p + 2);
      push_d(SL0, p + 3);
      wait_cyc(p + 4);
      req_digits[19:0] = SL0B;
      push_d(SL0B, p + 5);

      q = p + 7;
      wait_cyc(q);
      req = 4'b1000;
      push_g(4'b0000, 2'd0, 1'b0, q + 1);
      push_g(4'b1000, 2'd3, 1'b1, q + 2);
      push_d(IDLE_D, q + 2);
      push_d(SL3, q + 3);
      wait_cyc(q + 45);

      // Asynchronous reset between clock edges while requester 3 owns.
      @(posedge clk);
      #2;
      push_g(4'b0000, 2'd0, 1'b0, -1);
      push_d(IDLE_D, -1);
      tick_ok = 1'b0;
      reset = 1'b1;
      req = 4'b0000;
      #1;
      chk("async_grant", {28'b0, grant}, 32'd0);
      chk("async_busy", {31'b0, busy}, 32'd0);
      chk("async_owner", {30'b0, owner}, 32'd0);
      chk("async_digits", {12'b0, digits3, digits2, digits1, digits0}, {12'b0, IDLE_D});
      @(negedge clk);
      reset = 1'b0;
      r_cyc = cyc;
      tick_ok = 1'b1;
      repeat (2) @(negedge clk);

      req = 4'b1001;
      c = cyc;
      push_g(4'b0001, 2'd0, 1'b1, c + 1);
      push_d(SL0B, c + 2);
      wait_cyc(c + 4);
      req = 4'b0000;
      push_g(4'b0000, 2'd0, 1'b0, c + 5);
      push_d(IDLE_D, c + 6);

      for (int i = 0; i < 20; i++) begin
         if (gq.size() == 0 && dq.size() == 0) break;
         @(negedge clk);
      end
      chk("queues_drained", gq.size() + dq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
